// File: rtl/draw_cmd_engine.sv
// draw_cmd_engine: accepts one drawing command at a time and turns it into a
// raster of single-pixel writes to a VGA frame buffer. Coordinates arrive in
// superpixel units; each superpixel covers SPIXEL_W x SPIXEL_H physical pixels.
// The physical bounding box is scanned row-major at one pixel per cycle.
// Addresses advance by adders only, so the scan loop contains no multiplier.
module draw_cmd_engine #(
  parameter int SPIXEL_X_WIDTH = 5,
  parameter int SPIXEL_Y_WIDTH = 5,
  parameter int SPIXEL_X_MAX   = 31,
  parameter int SPIXEL_Y_MAX   = 23,
  parameter int SPIXEL_W       = 20,
  parameter int SPIXEL_H       = 20,
  parameter int PIXEL_X_MAX    = 639,
  parameter int ADDR_WIDTH     = 19,
  parameter int COLOR_WIDTH    = 8,
  parameter int CMD_WIDTH      = 4 + 2 * (SPIXEL_X_WIDTH + SPIXEL_Y_WIDTH) + COLOR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   icmd_vld,
  input  logic [CMD_WIDTH-1:0]   icmd,
  output logic                   ocmd_rdy,
  output logic [ADDR_WIDTH-1:0]  oaddr,
  output logic [COLOR_WIDTH-1:0] odata,
  output logic                   owren,
  output logic                   obusy,
  output logic                   odone,
  output logic                   oerr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Opcode values
  localparam logic [3:0] OP_PIXEL   = 4'd0;
  localparam logic [3:0] OP_OUTLINE = 4'd2;
  localparam logic [3:0] OP_CLEAR   = 4'd3;

  // Geometry constants, pre-sized to the widths they are used at
  localparam int PITCH  = PIXEL_X_MAX + 1;
  localparam int SUBX_W = (SPIXEL_W > 1) ? $clog2(SPIXEL_W) : 1;
  localparam int SUBY_W = (SPIXEL_H > 1) ? $clog2(SPIXEL_H) : 1;

  localparam logic [ADDR_WIDTH-1:0]     A_PITCH      = ADDR_WIDTH'(PITCH);
  localparam logic [ADDR_WIDTH-1:0]     A_ROW_STRIDE = ADDR_WIDTH'(SPIXEL_H * PITCH);
  localparam logic [ADDR_WIDTH-1:0]     A_SPIXEL_W   = ADDR_WIDTH'(SPIXEL_W);
  localparam logic [SPIXEL_X_WIDTH-1:0] X_LAST       = SPIXEL_X_WIDTH'(SPIXEL_X_MAX);
  localparam logic [SPIXEL_Y_WIDTH-1:0] Y_LAST       = SPIXEL_Y_WIDTH'(SPIXEL_Y_MAX);
  localparam logic [SUBX_W-1:0]         SUBX_LAST    = SUBX_W'(SPIXEL_W - 1);
  localparam logic [SUBY_W-1:0]         SUBY_LAST    = SUBY_W'(SPIXEL_H - 1);

  // Command field positions, MSB first: opcode, x0, y0, x1, y1, colour
  localparam int OP_LSB = CMD_WIDTH - 4;
  localparam int X0_LSB = OP_LSB - SPIXEL_X_WIDTH;
  localparam int Y0_LSB = X0_LSB - SPIXEL_Y_WIDTH;
  localparam int X1_LSB = Y0_LSB - SPIXEL_X_WIDTH;
  localparam int Y1_LSB = X1_LSB - SPIXEL_Y_WIDTH;

  // FSM state
  state_t r_state;
  state_t w_state_nxt;

  // Latched command
  logic [3:0]                r_op;
  logic [SPIXEL_X_WIDTH-1:0] r_x0;
  logic [SPIXEL_X_WIDTH-1:0] r_x1;
  logic [SPIXEL_Y_WIDTH-1:0] r_y0;
  logic [SPIXEL_Y_WIDTH-1:0] r_y1;
  logic [COLOR_WIDTH-1:0]    r_color;

  // Scan position: superpixel coordinate plus offset inside the superpixel
  logic [SPIXEL_X_WIDTH-1:0] r_sx;
  logic [SPIXEL_Y_WIDTH-1:0] r_sy;
  logic [SUBX_W-1:0]         r_sub_x;
  logic [SUBY_W-1:0]         r_sub_y;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [ADDR_WIDTH-1:0]     r_row_base;

  // Decoded incoming command
  logic [3:0]                w_op;
  logic [SPIXEL_X_WIDTH-1:0] w_x0_raw;
  logic [SPIXEL_X_WIDTH-1:0] w_x1_raw;
  logic [SPIXEL_Y_WIDTH-1:0] w_y0_raw;
  logic [SPIXEL_Y_WIDTH-1:0] w_y1_raw;
  logic [COLOR_WIDTH-1:0]    w_color;
  logic [SPIXEL_X_WIDTH-1:0] w_x0c;
  logic [SPIXEL_X_WIDTH-1:0] w_x1c;
  logic [SPIXEL_Y_WIDTH-1:0] w_y0c;
  logic [SPIXEL_Y_WIDTH-1:0] w_y1c;
  logic [SPIXEL_X_WIDTH-1:0] w_bx0;
  logic [SPIXEL_X_WIDTH-1:0] w_bx1;
  logic [SPIXEL_Y_WIDTH-1:0] w_by0;
  logic [SPIXEL_Y_WIDTH-1:0] w_by1;
  logic [ADDR_WIDTH-1:0]     w_start;
  logic                      w_legal;
  logic                      w_accept;

  // Scan control
  logic w_row_end;
  logic w_box_end;
  logic w_border;
  logic w_op_illegal;

  function automatic logic [SPIXEL_X_WIDTH-1:0] f_clamp_x(input logic [SPIXEL_X_WIDTH-1:0] v);
    if ({1'b0, v} > {1'b0, X_LAST}) return X_LAST;
    return v;
  endfunction

  function automatic logic [SPIXEL_Y_WIDTH-1:0] f_clamp_y(input logic [SPIXEL_Y_WIDTH-1:0] v);
    if ({1'b0, v} > {1'b0, Y_LAST}) return Y_LAST;
    return v;
  endfunction

  assign w_op     = icmd[CMD_WIDTH-1 -: 4];
  assign w_x0_raw = icmd[X0_LSB +: SPIXEL_X_WIDTH];
  assign w_y0_raw = icmd[Y0_LSB +: SPIXEL_Y_WIDTH];
  assign w_x1_raw = icmd[X1_LSB +: SPIXEL_X_WIDTH];
  assign w_y1_raw = icmd[Y1_LSB +: SPIXEL_Y_WIDTH];
  assign w_color  = icmd[COLOR_WIDTH-1:0];

  assign w_x0c = f_clamp_x(w_x0_raw);
  assign w_x1c = f_clamp_x(w_x1_raw);
  assign w_y0c = f_clamp_y(w_y0_raw);
  assign w_y1c = f_clamp_y(w_y1_raw);

  assign w_legal  = (w_op[3:2] == 2'b00);
  assign w_accept = icmd_vld && (r_state == S_IDLE);

  // Normalise the incoming box: clamped, ordered, and special-cased per opcode
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    w_bx0 = (w_x0c <= w_x1c) ? w_x0c : w_x1c;
    w_bx1 = (w_x0c <= w_x1c) ? w_x1c : w_x0c;
    w_by0 = (w_y0c <= w_y1c) ? w_y0c : w_y1c;
    w_by1 = (w_y0c <= w_y1c) ? w_y1c : w_y0c;
    if (w_op == OP_CLEAR) begin
      w_bx0 = '0;
      w_by0 = '0;
      w_bx1 = X_LAST;
      w_by1 = Y_LAST;
    end else if (w_op == OP_PIXEL) begin
      w_bx0 = w_x0c;
      w_bx1 = w_x0c;
      w_by0 = w_y0c;
      w_by1 = w_y0c;
    end
  end

  // The only multiplies: box origin address, evaluated once at accept time
  assign w_start = ADDR_WIDTH'(w_by0) * A_ROW_STRIDE + ADDR_WIDTH'(w_bx0) * A_SPIXEL_W;

  assign w_row_end = (r_sub_x == SUBX_LAST) && (r_sx == r_x1);
  assign w_box_end = w_row_end && (r_sub_y == SUBY_LAST) && (r_sy == r_y1);
  assign w_border  = (r_sx == r_x0) || (r_sx == r_x1) || (r_sy == r_y0) || (r_sy == r_y1);
  assign w_op_illegal = (r_op[3:2] != 2'b00);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    ocmd_rdy    = 1'b0;
    owren       = 1'b0;
    obusy       = 1'b0;
    odone       = 1'b0;
    oerr        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ocmd_rdy = 1'b1;
        if (w_accept) w_state_nxt = w_legal ? S_RUN : S_DONE;
      end
      S_RUN: begin
        obusy = 1'b1;
        owren = (r_op != OP_OUTLINE) || w_border;
        if (w_box_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        obusy       = 1'b1;
        odone       = 1'b1;
        oerr        = w_op_illegal;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch at accept, then pixel-by-pixel scan advance during RUN
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the whole datapath is reset, so an aborted command leaves no
    // stale address, colour or box behind.
    if (rst) begin
      r_op       <= '0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_color    <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_sub_x    <= '0;
      r_sub_y    <= '0;
      r_addr     <= '0;
      r_row_base <= '0;
    end else if (w_accept) begin
      r_op       <= w_op;
      r_x0       <= w_bx0;
      r_x1       <= w_bx1;
      r_y0       <= w_by0;
      r_y1       <= w_by1;
      r_color    <= w_color;
      r_sx       <= w_bx0;
      r_sy       <= w_by0;
      r_sub_x    <= '0;
      r_sub_y    <= '0;
      r_addr     <= w_start;
      r_row_base <= w_start;
    end else if ((r_state == S_RUN) && !w_box_end) begin
      if (w_row_end) begin
        // Wrap to the left edge of the box on the next physical line
        r_row_base <= r_row_base + A_PITCH;
        r_addr     <= r_row_base + A_PITCH;
        r_sx       <= r_x0;
        r_sub_x    <= '0;
        if (r_sub_y == SUBY_LAST) begin
          r_sub_y <= '0;
          r_sy    <= r_sy + SPIXEL_Y_WIDTH'(1);
        end else begin
          r_sub_y <= r_sub_y + SUBY_W'(1);
        end
      end else begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        if (r_sub_x == SUBX_LAST) begin
          r_sub_x <= '0;
          r_sx    <= r_sx + SPIXEL_X_WIDTH'(1);
        end else begin
          r_sub_x <= r_sub_x + SUBX_W'(1);
        end
      end
    end
  end

  assign oaddr = r_addr;
  assign odata = r_color;

endmodule

// File: tb/tb_draw_cmd_engine.sv
// tb_draw_cmd_engine: directed and randomized commands on a default-size engine,
// each scan cycle compared against a pixel-list reference model, plus a
// scaled-down instance for the full-screen clear.
module tb_draw_cmd_engine;

  localparam int SW    = 20;
  localparam int SH    = 20;
  localparam int XM    = 31;
  localparam int YM    = 23;
  localparam int PITCH = 640;

  logic        clk = 1'b0;
  logic        rst;
  logic        icmd_vld;
  logic [31:0] icmd;
  logic        ocmd_rdy;
  logic [18:0] oaddr;
  logic [7:0]  odata;
  logic        owren, obusy, odone, oerr;

  logic        s_vld;
  logic [23:0] s_cmd;
  logic        s_rdy;
  logic [9:0]  s_addr;
  logic [7:0]  s_data;
  logic        s_wren, s_busy, s_done, s_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int addr;
    bit wr;
  } pix_t;

  pix_t exp_q[$];

  always #5 clk = ~clk;

  draw_cmd_engine dut (
    .clk(clk), .rst(rst), .icmd_vld(icmd_vld), .icmd(icmd), .ocmd_rdy(ocmd_rdy),
    .oaddr(oaddr), .odata(odata), .owren(owren), .obusy(obusy), .odone(odone), .oerr(oerr)
  );

  // 32 x 24 physical pixels, 4x4 superpixels, 8 x 6 superpixel grid
  draw_cmd_engine #(
    .SPIXEL_X_WIDTH(3), .SPIXEL_Y_WIDTH(3), .SPIXEL_X_MAX(7), .SPIXEL_Y_MAX(5),
    .SPIXEL_W(4), .SPIXEL_H(4), .PIXEL_X_MAX(31), .ADDR_WIDTH(10), .COLOR_WIDTH(8)
  ) dut_small (
    .clk(clk), .rst(rst), .icmd_vld(s_vld), .icmd(s_cmd), .ocmd_rdy(s_rdy),
    .oaddr(s_addr), .odata(s_data), .owren(s_wren), .obusy(s_busy), .odone(s_done), .oerr(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: list of (address, write) per scan cycle, from pixel geometry
  task automatic build_model(input int op, input int x0, input int y0, input int x1, input int y1);
    int bx0, by0, bx1, by1;
    pix_t p;
    exp_q.delete();
    if (op > 3) return;
    if (x0 > XM) x0 = XM;
    if (x1 > XM) x1 = XM;
    if (y0 > YM) y0 = YM;
    if (y1 > YM) y1 = YM;
    if (op == 3) begin
      bx0 = 0; by0 = 0; bx1 = XM; by1 = YM;
    end else if (op == 0) begin
      bx0 = x0; bx1 = x0; by0 = y0; by1 = y0;
    end else begin
      bx0 = (x0 < x1) ? x0 : x1;
      bx1 = (x0 < x1) ? x1 : x0;
      by0 = (y0 < y1) ? y0 : y1;
      by1 = (y0 < y1) ? y1 : y0;
    end
    for (int py = by0 * SH; py < (by1 + 1) * SH; py++) begin
      for (int px = bx0 * SW; px < (bx1 + 1) * SW; px++) begin
        p.addr = py * PITCH + px;
        p.wr   = (op != 2) || (px / SW == bx0) || (px / SW == bx1) ||
                 (py / SH == by0) || (py / SH == by1);
        exp_q.push_back(p);
      end
    end
  endtask

  // Issue one command (called on a falling edge) and check every cycle until idle
  task automatic run_cmd(input int op, input int x0, input int y0, input int x1, input int y1,
                         input int col, output int n_wr, output int first_wr,
                         output int last_wr, output int n_win);
    build_model(op, x0, y0, x1, y1);
    n_wr = 0; first_wr = -1; last_wr = -1; n_win = 0;
    chk("rdy_before", 32'(ocmd_rdy), 1);
    icmd_vld = 1'b1;
    icmd = {op[3:0], x0[4:0], y0[4:0], x1[4:0], y1[4:0], col[7:0]};
    @(negedge clk);
    foreach (exp_q[i]) begin
      icmd = $urandom;
      chk("busy_run", 32'(obusy), 1);
      chk("wren", 32'(owren), 32'(exp_q[i].wr));
      chk("addr", 32'(oaddr), exp_q[i].addr);
      if (exp_q[i].wr) chk("data", 32'(odata), col);
      if (owren === 1'b1) begin
        if (n_wr == 0) first_wr = int'(oaddr);
        last_wr = int'(oaddr);
        n_wr++;
        if (oaddr >= 19'd12820 && oaddr <= 19'd12839) n_win++;
      end
      @(negedge clk);
    end
    chk("done_pulse", 32'(odone), 1);
    chk("err_flag", 32'(oerr), 32'(op > 3));
    chk("wren_done", 32'(owren), 0);
    chk("rdy_done", 32'(ocmd_rdy), 0);
    @(negedge clk);
    icmd_vld = 1'b0;
    chk("rdy_after", 32'(ocmd_rdy), 1);
    chk("done_clear", 32'(odone), 0);
    chk("busy_idle", 32'(obusy), 0);
  endtask

  initial begin
    int n_wr, first_wr, last_wr, n_win;
    int op, x0, y0, x1, y1, cnt, cyc, n_done;

    rst = 1'b1; icmd_vld = 1'b0; icmd = '0; s_vld = 1'b0; s_cmd = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(ocmd_rdy), 1);
    chk("rst_wren", 32'(owren), 0);
    chk("rst_addr", 32'(oaddr), 0);
    chk("rst_data", 32'(odata), 0);
    chk("rst_busy", 32'(obusy), 0);
    chk("rst_done", 32'(odone), 0);
    chk("rst_err", 32'(oerr), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single superpixel
    run_cmd(0, 5, 5, 0, 0, 'h0f, n_wr, first_wr, last_wr, n_win);
    chk("px_count", n_wr, 400);
    chk("px_first", first_wr, 64100);
    chk("px_last", last_wr, 76279);

    // Filled rectangle, both corner orders
    run_cmd(1, 10, 10, 20, 14, 'haa, n_wr, first_wr, last_wr, n_win);
    chk("rect_count", n_wr, 22000);
    chk("rect_first", first_wr, 128200);
    chk("rect_last", last_wr, 191779);
    run_cmd(1, 20, 14, 10, 10, 'haa, n_wr, first_wr, last_wr, n_win);
    chk("rect_sw_count", n_wr, 22000);
    chk("rect_sw_first", first_wr, 128200);
    chk("rect_sw_last", last_wr, 191779);

    // Outline leaves the centre superpixel untouched
    run_cmd(2, 0, 0, 2, 2, 'h33, n_wr, first_wr, last_wr, n_win);
    chk("outl_count", n_wr, 3200);
    chk("outl_window", n_win, 0);

    // Out-of-range coordinates clamp to the last superpixel
    run_cmd(1, 31, 30, 31, 30, 'h5a, n_wr, first_wr, last_wr, n_win);
    chk("clamp_count", n_wr, 400);
    chk("clamp_last", last_wr, 307199);

    // Illegal opcode
    run_cmd(7, 3, 3, 4, 4, 'hff, n_wr, first_wr, last_wr, n_win);
    chk("ill_count", n_wr, 0);

    // Randomized small commands, including illegal opcodes and clamping
    for (int k = 0; k < 10; k++) begin
      op = $urandom_range(0, 11);
      if (op >= 10) op = $urandom_range(4, 15);
      else op = op % 3;
      x0 = $urandom_range(0, 31);
      y0 = $urandom_range(0, 31);
      x1 = x0 + $urandom_range(0, 2) - 1;
      y1 = y0 + $urandom_range(0, 2) - 1;
      if (x1 < 0) x1 = 0;
      if (x1 > 31) x1 = 31;
      if (y1 < 0) y1 = 0;
      if (y1 > 31) y1 = 31;
      run_cmd(op, x0, y0, x1, y1, $urandom_range(0, 255), n_wr, first_wr, last_wr, n_win);
    end

    // Reset during a rectangle, then a normal command right after release
    icmd_vld = 1'b1;
    icmd = {4'd1, 5'd0, 5'd0, 5'd3, 5'd3, 8'h77};
    @(negedge clk);
    icmd_vld = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 1000 && cyc < 5000) begin
      if (owren === 1'b1) cnt++;
      if (cnt < 1000) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("abort_reached", cnt, 1000);
    rst = 1'b1;
    #1;
    chk("abort_wren", 32'(owren), 0);
    chk("abort_addr", 32'(oaddr), 0);
    chk("abort_busy", 32'(obusy), 0);
    chk("abort_rdy", 32'(ocmd_rdy), 1);
    chk("abort_data", 32'(odata), 0);
    @(negedge clk);
    chk("abort_hold", 32'(owren), 0);
    rst = 1'b0;
    run_cmd(0, 2, 3, 9, 9, 'h3c, n_wr, first_wr, last_wr, n_win);
    chk("post_rst_count", n_wr, 400);
    chk("post_rst_first", first_wr, 38440);

    // Clear screen on the small instance: every address exactly once, in order
    s_vld = 1'b1;
    s_cmd = {4'd3, 12'hfff, 8'h00};
    @(negedge clk);
    s_vld = 1'b0;
    cnt = 0; n_done = 0;
    for (int c = 0; c < 800; c++) begin
      if (s_wren === 1'b1) begin
        chk("clr_addr", 32'(s_addr), cnt);
        chk("clr_data", 32'(s_data), 0);
        cnt++;
      end
      if (s_done === 1'b1) n_done++;
      @(negedge clk);
    end
    chk("clr_count", cnt, 768);
    chk("clr_done_once", n_done, 1);
    chk("clr_idle", 32'(s_rdy), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
